// File: rtl/fft_sample_ram_if.sv
// rtl/fft_sample_ram_if.sv - host/core/mode signal bundle for the FFT sample memory
interface fft_sample_ram_if #(
   parameter int SAMPLE_W = 16,
   parameter int ADDR_W   = 12
);
   logic                    mode_req;
   logic                    mode;
   logic                    mode_busy;

   logic                    host_wr_en;
   logic                    host_rd_en;
   logic [ADDR_W-1:0]       host_addr;
   logic [SAMPLE_W-1:0]     host_wdata;
   logic [2*SAMPLE_W-1:0]   host_rdata;
   logic                    host_rvalid;
   logic                    host_err;
   logic [ADDR_W:0]         fill_count;

   logic                    core_wr_en;
   logic [ADDR_W-1:0]       core_wr_addr;
   logic [2*SAMPLE_W-1:0]   core_wdata;
   logic                    core_rd_en;
   logic [ADDR_W-1:0]       core_rd_addr;
   logic [2*SAMPLE_W-1:0]   core_rdata;
   logic                    core_rvalid;

   modport slave (
      input  mode_req,
      output mode, mode_busy,
      input  host_wr_en, host_rd_en, host_addr, host_wdata,
      output host_rdata, host_rvalid, host_err, fill_count,
      input  core_wr_en, core_wr_addr, core_wdata, core_rd_en, core_rd_addr,
      output core_rdata, core_rvalid
   );

   modport master (
      output mode_req,
      input  mode, mode_busy,
      output host_wr_en, host_rd_en, host_addr, host_wdata,
      input  host_rdata, host_rvalid, host_err, fill_count,
      output core_wr_en, core_wr_addr, core_wdata, core_rd_en, core_rd_addr,
      input  core_rdata, core_rvalid
   );
endinterface

// File: rtl/fft_sample_ram.sv
// rtl/fft_sample_ram.sv - sample memory shared between the host loader and the FFT core
// Ownership moves between HOST and CORE through a one-cycle SWITCH guard state.
module fft_sample_ram #(
   parameter int SAMPLE_W = 16,
   parameter int ADDR_W   = 12
) (
   input  logic                clk,
   input  logic                rst,
   fft_sample_ram_if.slave     bus
);
   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      ST_HOST   = 2'd0,
      ST_CORE   = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    mode_q, mode_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;
   logic [ADDR_W:0]         fill_q, fill_d;

   logic [2*SAMPLE_W-1:0]   mem_q [DEPTH];
   logic [2*SAMPLE_W-1:0]   host_rdata_q;
   logic                    host_rvalid_q;
   logic [2*SAMPLE_W-1:0]   core_rdata_q;
   logic                    core_rvalid_q;

   logic                    in_host, in_core;
   logic                    host_wr_ok, host_rd_ok;
   logic                    core_wr_ok, core_rd_ok;

   // Access acceptance uses the current state, so a transition cycle is
   // still serviced under the old owner.
   assign in_host    = (state_q == ST_HOST);
   assign in_core    = (state_q == ST_CORE);
   assign host_wr_ok = in_host & bus.host_wr_en;
   assign host_rd_ok = in_host & bus.host_rd_en & ~bus.host_wr_en;
   assign core_wr_ok = in_core & bus.core_wr_en;
   assign core_rd_ok = in_core & bus.core_rd_en;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      unique case (state_q)
         ST_HOST, ST_CORE: begin
            if (bus.mode_req != mode_q) state_d = ST_SWITCH;
         end
         ST_SWITCH: begin
            state_d = bus.mode_req ? ST_CORE : ST_HOST;
            mode_d  = bus.mode_req;
         end
         default: begin
            state_d = ST_HOST;
            mode_d  = 1'b0;
         end
      endcase
      busy_d = (state_d == ST_SWITCH);
   end

   always_comb begin
      err_d = ((bus.host_wr_en | bus.host_rd_en) & ~in_host)
            | (in_host & bus.host_wr_en & bus.host_rd_en);
      fill_d = fill_q;
      if (state_q == ST_SWITCH && state_d == ST_HOST) begin
         fill_d = '0;
      end else if (host_wr_ok && fill_q != FILL_MAX) begin
         fill_d = fill_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HOST;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         fill_q  <= fill_d;
      end
   end

   // Contents survive reset; only one owner can write in any given state.
   always_ff @(posedge clk) begin
      if (host_wr_ok) begin
         mem_q[bus.host_addr] <= {{SAMPLE_W{1'b0}}, bus.host_wdata};
      end else if (core_wr_ok) begin
         mem_q[bus.core_wr_addr] <= bus.core_wdata;
      end
   end

   // Read ports sample the array before this edge's write lands: read-first.
   always_ff @(posedge clk) begin
      if (rst) begin
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
         core_rdata_q  <= '0;
         core_rvalid_q <= 1'b0;
      end else begin
         host_rvalid_q <= host_rd_ok;
         core_rvalid_q <= core_rd_ok;
         if (host_rd_ok) host_rdata_q <= mem_q[bus.host_addr];
         if (core_rd_ok) core_rdata_q <= mem_q[bus.core_rd_addr];
      end
   end

   assign bus.mode        = mode_q;
   assign bus.mode_busy   = busy_q;
   assign bus.host_rdata  = host_rdata_q;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.host_err    = err_q;
   assign bus.fill_count  = fill_q;
   assign bus.core_rdata  = core_rdata_q;
   assign bus.core_rvalid = core_rvalid_q;
endmodule
